// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial lookahead adder:
// FSM state encoding, nibble width and counter sizing helper.
package cla_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index counter width for WIDTH/NIBBLE nibbles, never narrower than 1 bit.
  function automatic int idx_width(input int width);
    return (width / NIBBLE > 1) ? $clog2(width / NIBBLE) : 1;
  endfunction

endpackage

// File: rtl/cla4_carry.sv
// 4-bit lookahead carry unit: generate/propagate terms expanded into the
// flat two-level sum-of-products form for every carry C1..C4.
module cla4_carry
  import cla_pkg::*;
(
  input  logic [NIBBLE-1:0] x,
  input  logic [NIBBLE-1:0] y,
  input  logic              c0,
  output logic [4:1]        c
);

  logic [NIBBLE-1:0] g;
  logic [NIBBLE-1:0] p;

  assign g = x & y;
  assign p = x | y;

  assign c[1] = g[0]
              | (p[0] & c0);

  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c0);

  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);

  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

endmodule

// File: rtl/cla_seq_adder16.sv
// Sequential adder: one 4-bit lookahead nibble per cycle, LS nibble first,
// with the nibble carry rippled through a register between cycles.
module cla_seq_adder16
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NUM_NIB = WIDTH / NIBBLE;
  localparam int IDX_W   = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [IDX_W-1:0] idx_reg;

  logic [NIBBLE-1:0] a_nib [NUM_NIB];
  logic [NIBBLE-1:0] b_nib [NUM_NIB];
  logic [NIBBLE-1:0] x;
  logic [NIBBLE-1:0] y;
  logic [NIBBLE-1:0] nib_sum;
  logic [4:1]        c;
  logic              last_nib;

  for (genvar gi = 0; gi < NUM_NIB; gi++) begin : g_nib
    assign a_nib[gi] = a_reg[gi*NIBBLE +: NIBBLE];
    assign b_nib[gi] = b_reg[gi*NIBBLE +: NIBBLE];
  end

  assign x        = a_nib[idx_reg];
  assign y        = b_nib[idx_reg];
  assign last_nib = (idx_reg == LAST_IDX);

  cla4_carry u_carry (
    .x  (x),
    .y  (y),
    .c0 (carry_reg),
    .c  (c)
  );

  // Bit i of the nibble uses the lookahead carry into that bit position.
  assign nib_sum = x ^ y ^ {c[3:1], carry_reg};

  always_comb begin
    sum_next = sum_reg;
    for (int i = 0; i < NUM_NIB; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        sum_next[i*NIBBLE +: NIBBLE] = nib_sum;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_nib) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            sum_reg   <= '0;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= c[4];
          if (last_nib) begin
            // Carry into and out of the MSB decide the signed overflow.
            cout_reg <= c[4];
            ovf_reg  <= c[3] ^ c[4];
            idx_reg  <= '0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_cla_seq_adder16.sv
// Directed-vector and random checks of the nibble-serial adder at WIDTH=16 and WIDTH=8.
module tb_cla_seq_adder16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start16, cin16, ready16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        start8, cin8, ready8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  cla_seq_adder16 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .ready(ready16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  cla_seq_adder16 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic st);
    if (w8) begin
      a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; start8 = st;
    end else begin
      a16 = av; b16 = bv; cin16 = cv; start16 = st;
    end
  endtask

  task automatic sample(input bit w8, output logic dn, output logic rdy,
                        output logic [15:0] s, output logic co, output logic ov);
    if (w8) begin
      dn = done8; rdy = ready8; s = {8'h00, sum8}; co = cout8; ov = ovf8;
    end else begin
      dn = done16; rdy = ready16; s = sum16; co = cout16; ov = ovf16;
    end
  endtask

  // One operation: start in IDLE, scramble inputs after capture (optionally with
  // start held high through RUN and DONE), check latency, pulse width and hold.
  task automatic run_op(input bit w8, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input bit meddle, input int exp_lat,
                        output logic [15:0] s, output logic co, output logic ov);
    int          lat;
    logic        dn, rdy, co2, ov2;
    logic [15:0] s2;
    @(negedge clk);
    drive(w8, av, bv, cv, 1'b1);
    @(posedge clk);
    #1;
    drive(w8, ~av, ~bv, ~cv, meddle);
    lat = 1;
    sample(w8, dn, rdy, s, co, ov);
    while (!dn && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      sample(w8, dn, rdy, s, co, ov);
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("done seen", dn, 1'b1);
    drive(w8, 16'h5a5a, 16'h3c3c, 1'b1, meddle);
    @(posedge clk);
    #1;
    sample(w8, dn, rdy, s2, co2, ov2);
    check("done one cycle", dn, 1'b0);
    check("ready after done", rdy, 1'b1);
    check("sum held", s2, s);
    check("flags held", {co2, ov2}, {co, ov});
    drive(w8, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] s, ra, rb;
    logic        co, ov, rc;
    logic [16:0] full16;
    logic [8:0]  full8;

    vecs[0] = '{"ffff+0001",       16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{"7fff+0001",       16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{"1234+4321+1",     16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{"8000+8000 b2b",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{"0000+0000+1",     16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{"ffff+ffff+1",     16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{"8000+ffff",       16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst ready16", ready16, 1'b1);
    check("rst done16", done16, 1'b0);
    check("rst sum16", sum16, 16'h0);
    check("rst cout16", cout16, 1'b0);
    check("rst ovf16", ovf16, 1'b0);
    check("rst ready8", ready8, 1'b1);
    check("rst done8", done8, 1'b0);
    check("rst sum8", sum8, 8'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed table; consecutive entries start in the IDLE cycle after DONE.
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 5, s, co, ov);
      check({vecs[i].name, " sum"}, s, vecs[i].s);
      check({vecs[i].name, " cout"}, co, vecs[i].co);
      check({vecs[i].name, " ovf"}, ov, vecs[i].ov);
      $display("[TB] %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d",
               vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov);
    end

    // Reset asserted during the third RUN cycle aborts without a done pulse.
    @(negedge clk);
    drive(1'b0, 16'h1111, 16'h1111, 1'b0, 1'b1);
    @(posedge clk);
    #1 drive(1'b0, 16'h1111, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("partial sum", sum16, 16'h0022);
    check("cout before abort", cout16, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort sum", sum16, 16'h0);
    check("abort cout", cout16, 1'b0);
    check("abort ovf", ovf16, 1'b0);
    check("abort ready", ready16, 1'b1);
    check("abort done", done16, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check("done during reset", done16, 1'b0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("done after release", done16, 1'b0);
    run_op(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 5, s, co, ov);
    check("post-reset sum", s, 16'h1000);
    check("post-reset flags", {co, ov}, 2'b00);
    $display("[TB] post-reset: 0f0f+00f1 -> sum=%h cout=%0d ovf=%0d", s, co, ov);

    // Start held high with different operands through RUN and DONE is ignored.
    run_op(1'b0, 16'h2222, 16'h1111, 1'b0, 1'b1, 5, s, co, ov);
    check("meddle sum", s, 16'h3333);
    check("meddle flags", {co, ov}, 2'b00);
    $display("[TB] meddle: 2222+1111 -> sum=%h cout=%0d ovf=%0d", s, co, ov);

    // Random operands against an arithmetic model, both widths.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      full16 = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      run_op(1'b0, ra, rb, rc, 1'b0, 5, s, co, ov);
      check("rand16 sum", s, full16[15:0]);
      check("rand16 cout", co, full16[16]);
      check("rand16 ovf", ov, (ra[15] == rb[15]) && (full16[15] != ra[15]));
      $display("[TB] r16 %0d: %h+%h+%0d -> %h c%0d v%0d", i, ra, rb, rc, s, co, ov);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(255)); rb = 16'($urandom_range(255)); rc = 1'($urandom);
      full8 = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + {8'h0, rc};
      run_op(1'b1, ra, rb, rc, 1'b0, 3, s, co, ov);
      check("rand8 sum", s, {8'h00, full8[7:0]});
      check("rand8 cout", co, full8[8]);
      check("rand8 ovf", ov, (ra[7] == rb[7]) && (full8[7] != ra[7]));
      $display("[TB] r8 %0d: %h+%h+%0d -> %h c%0d v%0d", i, ra[7:0], rb[7:0], rc, s[7:0], co, ov);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
